// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD character-buffer write arbiter.
// The line base addresses match the display controller's DDRAM layout.
package lcd_pkg;

  localparam int COLS  = 20;
  localparam int LINES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } lcd_state_e;

  localparam logic [6:0] LINE_BASE [LINES] = '{7'h00, 7'h40, 7'h14, 7'h54};

  // Column advance that stays on the same line.
  function automatic logic [4:0] col_wrap(input logic [4:0] col, input logic [4:0] last);
    logic [4:0] nxt;
    if (col == last) begin
      nxt = 5'd0;
    end else begin
      nxt = col + 5'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Round-robin request picker: first set request at or after the pointer,
// searching upward with wrap. Purely combinational; the owner keeps the pointer.
module lcd_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_valid
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  // Rotating priority search from the pointer.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N_REQ)) begin
        w_sum = w_sum - (IW+1)'(N_REQ);
      end else begin
        w_sum = w_sum;
      end
      w_cand = w_sum[IW-1:0];
      if (i_en && !o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/lcd_text_arbiter.sv
// Shares the LCD character-buffer write port between N_REQ requesters:
// round-robin grant, per-line column stream with wrap, valid/ready handshake.
module lcd_text_arbiter #(
  parameter int N_REQ = 4,
  parameter int COLS  = 20
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N_REQ-1:0]     Req,
  input  logic [2*N_REQ-1:0]   ReqLine,
  input  logic [5*N_REQ-1:0]   ReqStart,
  input  logic [5*N_REQ-1:0]   ReqLen,
  input  logic [8*N_REQ-1:0]   CharData,
  input  logic [N_REQ-1:0]     CharValid,
  output logic [N_REQ-1:0]     CharReady,
  output logic [N_REQ-1:0]     Grant,
  output logic [N_REQ-1:0]     Done,
  output logic                 Err,
  output logic [1:0]           Line,
  output logic [4:0]           Address,
  output logic [7:0]           Data,
  output logic                 Latch
);

  import lcd_pkg::*;

  localparam int         IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [4:0] COLS_W   = 5'(COLS);
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);

  lcd_state_e        r_state;
  logic [N_REQ-1:0]  r_grant;
  logic [IW-1:0]     r_gidx;
  logic [IW-1:0]     r_ptr;
  logic [1:0]        r_line;
  logic [4:0]        r_col;
  logic [4:0]        r_cnt;
  logic [N_REQ-1:0]  r_done;
  logic              r_err;
  logic              r_latch;
  logic [1:0]        r_line_o;
  logic [4:0]        r_addr;
  logic [7:0]        r_data;

  logic [1:0]        w_line_a  [N_REQ];
  logic [4:0]        w_start_a [N_REQ];
  logic [4:0]        w_len_a   [N_REQ];
  logic [7:0]        w_data_a  [N_REQ];

  logic [N_REQ-1:0]  w_win;
  logic [IW-1:0]     w_win_idx;
  logic              w_win_vld;
  logic              w_arb_en;
  logic              w_xfer;
  logic              w_req_g;
  logic              w_valid_g;
  logic [7:0]        w_data_g;
  logic              w_beat;
  logic [IW-1:0]     w_ptr_nxt;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_line_a[i]  = ReqLine[2*i +: 2];
    assign w_start_a[i] = ReqStart[5*i +: 5];
    assign w_len_a[i]   = ReqLen[5*i +: 5];
    assign w_data_a[i]  = CharData[8*i +: 8];
  end

  assign w_arb_en = (r_state == ST_IDLE);

  lcd_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .i_req   (Req),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_win),
    .o_idx   (w_win_idx),
    .o_valid (w_win_vld)
  );

  // Owner-side views of the handshake and the post-completion pointer.
  always_comb begin
    w_xfer    = (r_state == ST_XFER);
    w_req_g   = Req[r_gidx];
    w_valid_g = CharValid[r_gidx];
    w_data_g  = w_data_a[r_gidx];
    w_beat    = w_valid_g & w_xfer;
    if (r_gidx == IW'(N_REQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = r_gidx + IW'(1);
    end
  end

  assign CharReady = r_grant & {N_REQ{w_xfer}};
  assign Grant     = r_grant;
  assign Done      = r_done;
  assign Err       = r_err;
  assign Latch     = r_latch;
  assign Line      = r_line_o;
  assign Address   = r_addr;
  assign Data      = r_data;

  // Arbitration / transfer state machine with registered buffer write port.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_ptr    <= '0;
      r_line   <= 2'd0;
      r_col    <= 5'd0;
      r_cnt    <= 5'd0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_latch  <= 1'b0;
      r_line_o <= 2'd0;
      r_addr   <= 5'd0;
      r_data   <= 8'd0;
    end else begin
      r_latch <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_done <= '0;
          r_err  <= 1'b0;
          if (w_win_vld) begin
            r_grant <= w_win;
            r_gidx  <= w_win_idx;
            r_line  <= w_line_a[w_win_idx];
            r_col   <= w_start_a[w_win_idx];
            r_cnt   <= w_len_a[w_win_idx];
            r_state <= ST_CHECK;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (!w_req_g || (r_col >= COLS_W) || (r_cnt == 5'd0)) begin
            r_done  <= r_grant;
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            if (r_cnt > COLS_W) begin
              r_cnt <= COLS_W;
            end else begin
              r_cnt <= r_cnt;
            end
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // A dropped request wins over a beat in the same cycle.
          if (!w_req_g) begin
            r_done  <= r_grant;
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_beat) begin
            r_latch  <= 1'b1;
            r_line_o <= r_line;
            r_addr   <= r_col;
            r_data   <= w_data_g;
            r_col    <= col_wrap(r_col, LAST_COL);
            r_cnt    <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) begin
              r_done  <= r_grant;
              r_err   <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_XFER;
            end
          end else begin
            r_state <= ST_XFER;
          end
        end
        ST_DONE: begin
          r_done  <= '0;
          r_err   <= 1'b0;
          r_grant <= '0;
          r_ptr   <= w_ptr_nxt;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= '0;
          r_err   <= 1'b0;
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Scoreboard bench for lcd_text_arbiter: expected buffer writes are queued at
// each handshake beat and popped when Latch fires.
module tb_lcd_text_arbiter;

  localparam int N = 4;
  localparam int C = 20;

  logic           Clk;
  logic           Reset;
  logic [N-1:0]   Req;
  logic [2*N-1:0] ReqLine;
  logic [5*N-1:0] ReqStart;
  logic [5*N-1:0] ReqLen;
  logic [8*N-1:0] CharData;
  logic [N-1:0]   CharValid;
  logic [N-1:0]   CharReady;
  logic [N-1:0]   Grant;
  logic [N-1:0]   Done;
  logic           Err;
  logic [1:0]     Line;
  logic [4:0]     Address;
  logic [7:0]     Data;
  logic           Latch;

  int n_vec = 0;
  int n_err = 0;
  logic [14:0] exp_q [$];
  int          grant_log [$];

  lcd_text_arbiter #(.N_REQ(N), .COLS(C)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req       (Req),
    .ReqLine   (ReqLine),
    .ReqStart  (ReqStart),
    .ReqLen    (ReqLen),
    .CharData  (CharData),
    .CharValid (CharValid),
    .CharReady (CharReady),
    .Grant     (Grant),
    .Done      (Done),
    .Err       (Err),
    .Line      (Line),
    .Address   (Address),
    .Data      (Data),
    .Latch     (Latch)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: pops the scoreboard on Latch, checks hold otherwise.
  initial begin
    logic [14:0] e;
    logic [14:0] prev_wr;
    logic [N-1:0] prev_grant;
    bit prev_rst;
    prev_wr = '0;
    prev_grant = '0;
    prev_rst = 1'b1;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_rst = 1'b1;
        prev_grant = '0;
      end else begin
        if (Latch) begin
          if (exp_q.size() == 0) begin
            check("latch_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("latch_write", {17'd0, Line, Address, Data}, {17'd0, e});
          end
        end else if (!prev_rst) begin
          check("write_hold", {17'd0, Line, Address, Data}, {17'd0, prev_wr});
        end
        if (Grant != '0 && prev_grant == '0) begin
          for (int j = 0; j < N; j++) if (Grant[j]) grant_log.push_back(j);
        end
        prev_rst = 1'b0;
        prev_grant = Grant;
        prev_wr = {Line, Address, Data};
      end
    end
  end

  task automatic do_req(input int i, input logic [1:0] ln, input logic [4:0] st,
                        input logic [4:0] len, input logic [7:0] base,
                        input logic [31:0] vpat, input int abort_at,
                        input int exp_beats, input logic exp_err, input bit chk_lat);
    int col, beats, k, lat, cyc;
    bit fin;
    logic [7:0] ch;
    col = int'(st); beats = 0; k = 0; lat = -1; cyc = 0; fin = 1'b0;
    @(negedge Clk);
    ReqLine[2*i +: 2] = ln;
    ReqStart[5*i +: 5] = st;
    ReqLen[5*i +: 5] = len;
    CharValid[i] = 1'b0;
    Req[i] = 1'b1;
    while (!fin && cyc < 300) begin
      @(negedge Clk);
      cyc++;
      if (lat < 0 && Grant[i]) lat = cyc;
      if (Done[i]) begin
        fin = 1'b1;
        Req[i] = 1'b0;
        CharValid[i] = 1'b0;
        check($sformatf("done_vec%0d", i), {28'd0, Done}, 32'(1 << i));
        check($sformatf("done_err%0d", i), {31'd0, Err}, {31'd0, exp_err});
        check($sformatf("grant_at_done%0d", i), {28'd0, Grant}, 32'(1 << i));
        check($sformatf("beats%0d", i), 32'(beats), 32'(exp_beats));
        if (chk_lat) check($sformatf("grant_latency%0d", i), 32'(lat), 32'd1);
      end else begin
        if (abort_at >= 0 && beats == abort_at && CharReady[i]) Req[i] = 1'b0;
        ch = base + 8'(beats);
        CharData[8*i +: 8] = ch;
        CharValid[i] = CharReady[i] ? ((k < 32) ? vpat[k[4:0]] : 1'b1) : 1'b0;
        if (CharReady[i] && CharValid[i] && Req[i]) begin
          exp_q.push_back({ln, 5'(col), ch});
          col = (col == C - 1) ? 0 : col + 1;
          beats++;
        end
        if (CharReady[i]) k++;
      end
    end
    if (!fin) check($sformatf("done_timeout%0d", i), 32'd0, 32'd1);
    @(negedge Clk);
    check($sformatf("grant_drop%0d", i), {31'd0, Grant[i]}, 32'd0);
  endtask

  initial begin
    int w;
    Reset = 1'b1;
    Req = '0; ReqLine = '0; ReqStart = '0; ReqLen = '0;
    CharData = '0; CharValid = '0;
    @(negedge Clk);
    check("reset_outputs", {3'd0, Grant, CharReady, Done, Err, Latch, Line, Address, Data}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // "ABCD" on line 1 from column 3, back-to-back
    do_req(0, 2'd1, 5'd3, 5'd4, 8'h41, 32'hFFFF_FFFF, -1, 4, 1'b0, 1'b1);
    // wrap past the last column on line 2
    do_req(1, 2'd2, 5'd18, 5'd4, 8'h61, 32'hFFFF_FFFF, -1, 4, 1'b0, 1'b1);
    // oversize length clamps to a full line
    do_req(1, 2'd3, 5'd5, 5'd25, 8'h20, 32'hFFFF_FFFF, -1, C, 1'b0, 1'b0);
    // rejected requests
    do_req(3, 2'd0, 5'd20, 5'd3, 8'h00, 32'hFFFF_FFFF, -1, 0, 1'b1, 1'b0);
    do_req(3, 2'd0, 5'd2, 5'd0, 8'h00, 32'hFFFF_FFFF, -1, 0, 1'b1, 1'b0);

    grant_log.delete();
    fork
      begin
        do_req(0, 2'd0, 5'd0, 5'd2, 8'h50, 32'hFFFF_FFFF, -1, 2, 1'b0, 1'b0);
        do_req(0, 2'd0, 5'd10, 5'd2, 8'h70, 32'hFFFF_FFFF, -1, 2, 1'b0, 1'b0);
      end
      do_req(2, 2'd1, 5'd0, 5'd3, 8'h30, 32'hFFFF_FFFF, -1, 3, 1'b0, 1'b0);
    join
    check("rr_count", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() >= 3) begin
      check("rr_first", 32'(grant_log[0]), 32'd0);
      check("rr_second", 32'(grant_log[1]), 32'd2);
      check("rr_third", 32'(grant_log[2]), 32'd0);
    end

    // gappy CharValid 1,0,0,1,0,1
    do_req(0, 2'd2, 5'd7, 5'd3, 8'h41, 32'hFFFF_FFE9, -1, 3, 1'b0, 1'b0);
    // abort after two of five beats
    do_req(0, 2'd3, 5'd1, 5'd5, 8'h61, 32'hFFFF_FFFF, 2, 2, 1'b1, 1'b0);

    // asynchronous reset in the middle of a transfer
    @(negedge Clk);
    ReqLine[1:0] = 2'd0; ReqStart[4:0] = 5'd7; ReqLen[4:0] = 5'd10;
    CharValid[0] = 1'b0; Req[0] = 1'b1;
    w = 0;
    while (!CharReady[0] && w < 20) begin
      @(negedge Clk);
      w++;
    end
    check("reset_test_ready", {31'd0, CharReady[0]}, 32'd1);
    for (int b = 0; b < 2; b++) begin
      CharValid[0] = 1'b1;
      CharData[7:0] = 8'h30 + 8'(b);
      if (CharReady[0]) exp_q.push_back({2'd0, 5'(7 + b), 8'h30 + 8'(b)});
      @(negedge Clk);
    end
    CharValid[0] = 1'b0;
    #2 Reset = 1'b1;
    #1 check("reset_async", {3'd0, Grant, CharReady, Done, Err, Latch, Line, Address, Data}, 32'd0);
    @(negedge Clk);
    Req = '0;
    Reset = 1'b0;
    grant_log.delete();
    do_req(2, 2'd3, 5'd0, 5'd2, 8'h58, 32'hFFFF_FFFF, -1, 2, 1'b0, 1'b1);
    check("post_reset_grants", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() >= 1) check("post_reset_winner", 32'(grant_log[0]), 32'd2);

    repeat (3) @(negedge Clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
